// File: rtl/nios_timer_pkg.sv
// Shared definitions for masters that drive the Nios interval timer's 16-bit register slave:
// register map, control-word bit positions and the round sequencer's state encoding.
package nios_timer_pkg;

    // Timer slave register addresses
    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;
    localparam logic [2:0] SNAPL   = 3'd4;
    localparam logic [2:0] SNAPH   = 3'd5;

    // Control register bit positions
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_STS,
        ST_ROUND_END,
        ST_ABT_STOP,
        ST_ABT_CLR
    } state_t;

    // Builds a control word from its individual flags.
    function automatic logic [3:0] ctrl_word(input logic ito, input logic cont,
                                             input logic start_bit, input logic stop_bit);
        logic [3:0] w;
        w        = '0;
        w[ITO]   = ito;
        w[CONT]  = cont;
        w[START] = start_bit;
        w[STOP]  = stop_bit;
        return w;
    endfunction

endpackage

// File: rtl/nios_timer_round_sequencer.sv
// Avalon-MM write master that programs the interval timer once per game and then runs
// one-shot rounds, servicing and restarting the timer after every timeout.
module nios_timer_round_sequencer
    import nios_timer_pkg::*;
#(
    parameter int         ROUND_W        = 8,
    parameter logic [3:0] CTRL_START_VAL = ctrl_word(1'b1, 1'b0, 1'b1, 1'b0),
    parameter logic [3:0] CTRL_STOP_VAL  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        period,
    input  logic [ROUND_W-1:0] num_rounds,
    output logic               busy,
    output logic               round_tick,
    output logic               done,
    output logic               aborted,
    output logic [ROUND_W-1:0] round_count,
    output logic [2:0]         tmr_address,
    output logic               tmr_chipselect,
    output logic               tmr_write_n,
    output logic [15:0]        tmr_writedata,
    input  logic               tmr_irq
);

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        period_hi_q;
    logic [ROUND_W-1:0] rounds_q;

    logic               accept_start;
    logic               final_round;
    logic               cs_d;
    logic [2:0]         addr_d;
    logic [15:0]        data_d;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign final_round  = (rounds_q != '0) && (round_count == rounds_q);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_WR_PL;
            ST_WR_PL:     state_d = ST_WR_PH;
            ST_WR_PH:     state_d = ST_WR_CTRL;
            ST_WR_CTRL:   state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ:  if (tmr_irq) state_d = ST_CLR_STS;
            ST_CLR_STS:   state_d = ST_ROUND_END;
            ST_ROUND_END: state_d = final_round ? ST_IDLE : ST_WR_CTRL;
            ST_ABT_STOP:  state_d = ST_ABT_CLR;
            ST_ABT_CLR:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // Abort overrides any game state; the cleanup states themselves run to completion.
        if (abort && (state_q inside {ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_WAIT_IRQ,
                                      ST_CLR_STS, ST_ROUND_END})) begin
            state_d = ST_ABT_STOP;
        end
    end

    // Bus signals are decoded from the next state and registered, so each write
    // occupies exactly the cycle spent in its state.
    always_comb begin
        cs_d   = 1'b0;
        addr_d = STATUS;
        data_d = '0;
        case (state_d)
            ST_WR_PL: begin
                // Only reachable from IDLE, where period is being sampled this cycle.
                cs_d   = 1'b1;
                addr_d = PERIODL;
                data_d = period[15:0];
            end
            ST_WR_PH: begin
                cs_d   = 1'b1;
                addr_d = PERIODH;
                data_d = period_hi_q;
            end
            ST_WR_CTRL: begin
                cs_d   = 1'b1;
                addr_d = CONTROL;
                data_d = {12'h000, CTRL_START_VAL};
            end
            ST_CLR_STS, ST_ABT_CLR: begin
                cs_d   = 1'b1;
                addr_d = STATUS;
                data_d = '0;
            end
            ST_ABT_STOP: begin
                cs_d   = 1'b1;
                addr_d = CONTROL;
                data_d = {12'h000, CTRL_STOP_VAL};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            round_tick     <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            round_count    <= '0;
            period_hi_q    <= '0;
            rounds_q       <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
        end else begin
            busy           <= (state_d != ST_IDLE);
            round_tick     <= (state_d == ST_CLR_STS);
            done           <= (state_q == ST_ROUND_END) && (state_d == ST_IDLE);
            aborted        <= (state_q == ST_ABT_CLR);
            tmr_chipselect <= cs_d;
            tmr_write_n    <= !cs_d;
            tmr_address    <= addr_d;
            tmr_writedata  <= data_d;

            if (accept_start) begin
                period_hi_q <= period[31:16];
                rounds_q    <= num_rounds;
                round_count <= '0;
            end else if (state_d == ST_CLR_STS) begin
                round_count <= round_count + ROUND_W'(1);
            end
        end
    end

endmodule

// File: doc/nios_timer_round_sequencer.md
Name: nios_timer_round_sequencer

Overview:
- Avalon-MM master that sequences the Nios interval timer's 16-bit register slave (addr 0 status, 1 control, 2 period_l, 3 period_h) for multi-round game countdowns.
- On a start command it programs the period and runs N one-shot rounds. After each round it services the timer interrupt, clears the timeout, and restarts the timer.
- Sits between the game-control logic and the timer slave, so software no longer touches the timer during a game.

Parameters:
- ROUND_W, 8, width of num_rounds and round_count
- CTRL_START_VAL, 4'h5, control word for a round: ITO=1, CONT=0, START=1
- CTRL_STOP_VAL, 4'h8, control word for an abort: STOP=1, ITO=0

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start request; ignored while busy
- abort  in  1  one-cycle abort request; ignored while idle
- period  in  32  timer period, sampled on an accepted start
- num_rounds  in  ROUND_W  round count, sampled on an accepted start; 0 = run until abort
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- round_tick  out  1  one-cycle pulse per completed round
- done  out  1  one-cycle pulse after the final round is cleared
- aborted  out  1  one-cycle pulse when the abort cleanup finishes
- round_count  out  ROUND_W  rounds completed in the current game
- tmr_address  out  3  timer slave address
- tmr_chipselect  out  1  timer slave chipselect
- tmr_write_n  out  1  timer slave write strobe, active-low
- tmr_writedata  out  16  timer slave write data
- tmr_irq  in  1  timer interrupt (registered timeout flag AND ITO)

Behaviour:
- Reset values: busy=0, round_tick=0, done=0, aborted=0, round_count=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. FSM goes to IDLE.
- Reset is asynchronous. Asserting it mid-game returns to IDLE at once and issues no bus cleanup.
- All outputs are registered. Each bus write is exactly one cycle with chipselect=1 and write_n=0, since the slave has no waitrequest. Outside write cycles chipselect=0 and write_n=1. No reads are issued.
- FSM states and transitions:
  - IDLE: on start, latch period and num_rounds, clear round_count, go to WR_PL.
  - WR_PL: write addr 2 with period[15:0], go to WR_PH.
  - WR_PH: write addr 3 with period[31:16], go to WR_CTRL.
  - WR_CTRL: write addr 1 with CTRL_START_VAL, go to WAIT_IRQ.
  - WAIT_IRQ: stay until tmr_irq=1, then go to CLR_STS.
  - CLR_STS: write addr 0 with data 0, increment round_count (wrap-around), pulse round_tick, go to ROUND_END.
  - ROUND_END: if num_rounds!=0 and round_count==num_rounds, pulse done and go to IDLE; otherwise go to WR_CTRL. Later rounds do not rewrite the period.
  - ABT_STOP: write addr 1 with CTRL_STOP_VAL, go to ABT_CLR.
  - ABT_CLR: write addr 0, pulse aborted, go to IDLE.
- Timer interaction:
  - The timer's force_reload pulse follows the WR_PH write and coincides with the WR_CTRL write. The timer gives start priority over that pulse's stop, so the counter runs.
  - ROUND_END provides the one-cycle gap during which tmr_irq falls after the status clear. WAIT_IRQ therefore never re-detects a stale interrupt.
- Latency: first bus write occurs 1 cycle after start is accepted. Round restart occurs 3 cycles after tmr_irq is sampled high.
- Boundary conditions:
  - abort in any non-IDLE state goes to ABT_STOP next cycle; any in-flight single-cycle write completes first.
  - abort and tmr_irq in the same cycle: abort wins, no round_tick.
  - abort while already in ABT_STOP or ABT_CLR is ignored.
  - start while busy is ignored; start and abort together in IDLE: start is accepted.
  - num_rounds=0: rounds repeat indefinitely and round_count wraps 2^ROUND_W-1 → 0.
  - period=0 is legal; the timer fires on its next count.
  - round_count holds its value in IDLE until the next accepted start.

Decomposition:
- Shared package nios_timer_pkg holds:
  - timer register address constants: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5
  - control bit indices: ITO=0, CONT=1, START=2, STOP=3
  - the FSM state enum
- Single module, no sub-module. A bus-write helper is too thin to justify one.

Test Plan:
- Bench uses the real timer behind the master. period=32'h0000_0009, num_rounds=3 → writes (2,0x0009), (3,0x0000), (1,0x0005); three round_ticks, each ~11 cycles after its control write; done on the third; round_count=3; busy falls with done.
- period=32'h0001_0002 → period_l write of 0x0002 and period_h write of 0x0001 in consecutive cycles. Rounds 2+ issue only the control write, 3 cycles after each irq.
- abort during WAIT_IRQ of round 2 → writes (1,0x0008) then (0,0x0000), aborted pulses, no done, round_count=1, timer irq stays low.
- num_rounds=0, ROUND_W=8, period=0 → run 300 rounds: round_count wraps 255→0, then reaches 44; no done until abort.
- tmr_irq and abort in the same cycle → aborted pulses with no round_tick. start while busy → no effect on the bus sequence.
- reset_n asserted in WR_PH → all outputs return to reset values immediately; a new start after release performs the full three-write sequence.
